// File: rtl/ped_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ped_walk_ctrl
// Brief    : Pedestrian WALK/CLEAR controller driven by the vehicle light code.
//            Optional macro PED_FLASH_EN enables DONT_WALK flashing in CLEAR.
// Revision : 1.0 - initial release
// ============================================================================
module ped_walk_ctrl #(
    parameter int WALK_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 3,
    parameter int DEBOUNCE     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       flash,
    output logic       req_pending,
    output logic       req_ack,
    output logic [3:0] remaining,
    output logic       fault
);

    localparam logic [1:0] c_red     = 2'b00;
    localparam logic [1:0] c_green   = 2'b01;
    localparam logic [1:0] c_illegal = 2'b10;
    localparam logic [3:0] c_walk    = 4'(WALK_CYCLES);
    localparam logic [3:0] c_clear   = 4'(CLEAR_CYCLES);
    localparam logic [3:0] c_db_last = 4'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_CLEAR = 2'd2,
        S_FAULT = 2'd3
    } fsm_t;

    fsm_t       r_fsm, w_fsm_nxt;
    logic       r_sync1, r_sync2, r_btn_db, r_btn_db_d;
    logic [3:0] r_db_cnt;
    logic [1:0] r_prev_state;
    logic       w_btn_rise, w_red_entry;
    logic       w_walk_nxt, w_dw_nxt, w_flash_nxt, w_ack_nxt, w_fault_nxt, w_pend_nxt;
    logic [3:0] w_rem_nxt;

    // Level only moves after DEBOUNCE consecutive samples disagreeing with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
            r_db_cnt   <= 4'd0;
        end else begin
            r_sync1    <= ped_btn;
            r_sync2    <= r_sync1;
            r_btn_db_d <= r_btn_db;
            if (r_sync2 != r_btn_db) begin
                if (r_db_cnt == c_db_last) begin
                    r_btn_db <= r_sync2;
                    r_db_cnt <= 4'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 4'd1;
                end
            end else begin
                r_db_cnt <= 4'd0;
            end
        end
    end

    assign w_btn_rise  = r_btn_db & ~r_btn_db_d;
    assign w_red_entry = (state == c_red) && (r_prev_state != c_red);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm        <= S_IDLE;
            r_prev_state <= c_green;
            walk         <= 1'b0;
            dont_walk    <= 1'b1;
            flash        <= 1'b0;
            req_pending  <= 1'b0;
            req_ack      <= 1'b0;
            remaining    <= 4'd0;
            fault        <= 1'b0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_prev_state <= state;
            walk         <= w_walk_nxt;
            dont_walk    <= w_dw_nxt;
            flash        <= w_flash_nxt;
            req_pending  <= w_pend_nxt;
            req_ack      <= w_ack_nxt;
            remaining    <= w_rem_nxt;
            fault        <= w_fault_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_walk_nxt  = 1'b0;
        w_dw_nxt    = 1'b1;
        w_flash_nxt = 1'b0;
        w_ack_nxt   = 1'b0;
        w_rem_nxt   = remaining;
        w_fault_nxt = fault;
        w_pend_nxt  = req_pending | w_btn_rise;
        if (state == c_illegal) begin
            w_fsm_nxt   = S_FAULT;
            w_fault_nxt = 1'b1;
            w_rem_nxt   = 4'd0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    w_rem_nxt = 4'd0;
                    // Grant overrides a same-cycle new request edge.
                    if (w_red_entry && req_pending && !fault) begin
                        w_fsm_nxt  = S_WALK;
                        w_walk_nxt = 1'b1;
                        w_dw_nxt   = 1'b0;
                        w_ack_nxt  = 1'b1;
                        w_pend_nxt = 1'b0;
                        w_rem_nxt  = c_walk;
                    end
                end
                S_WALK: begin
                    if (state != c_red) begin
                        w_fsm_nxt = S_IDLE;
                        w_rem_nxt = 4'd0;
                    end else if (remaining <= 4'd1) begin
                        w_fsm_nxt = S_CLEAR;
                        w_rem_nxt = c_clear;
`ifdef PED_FLASH_EN
                        w_flash_nxt = 1'b1;
`endif
                    end else begin
                        w_walk_nxt = 1'b1;
                        w_dw_nxt   = 1'b0;
                        w_rem_nxt  = remaining - 4'd1;
                    end
                end
                S_CLEAR: begin
                    if (state != c_red || remaining <= 4'd1) begin
                        w_fsm_nxt = S_IDLE;
                        w_rem_nxt = 4'd0;
                    end else begin
                        w_rem_nxt = remaining - 4'd1;
`ifdef PED_FLASH_EN
                        w_flash_nxt = ~flash;
`endif
                    end
                end
                default: begin
                    w_rem_nxt = 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ped_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ped_walk_ctrl
// Brief    : Directed self-checking bench for ped_walk_ctrl (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ped_walk_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] state;
    logic       ped_btn;
    logic       walk, dont_walk, flash, req_pending, req_ack, fault;
    logic [3:0] remaining;

    int n_assert = 0;
    int n_fail   = 0;

    ped_walk_ctrl #(.WALK_CYCLES(4), .CLEAR_CYCLES(3), .DEBOUNCE(3)) dut (
        .clk(clk), .rst(rst), .state(state), .ped_btn(ped_btn),
        .walk(walk), .dont_walk(dont_walk), .flash(flash),
        .req_pending(req_pending), .req_ack(req_ack),
        .remaining(remaining), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Flash expectation inside CLEAR depends on the build option.
    function automatic logic fl(input logic v);
`ifdef PED_FLASH_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic press_and_latch(input string tag);
        ped_btn = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk({tag, "_pend_early"}, {3'b0, req_pending}, 4'd0);
        step();
        chk({tag, "_pend_set"}, {3'b0, req_pending}, 4'd1);
        ped_btn = 1'b0;
        for (int i = 0; i < 7; i++) step();
    endtask

    initial begin
        rst = 1'b1; state = 2'b01; ped_btn = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_walk", {3'b0, walk}, 4'd0);
        chk("rst_dw", {3'b0, dont_walk}, 4'd1);
        chk("rst_flash", {3'b0, flash}, 4'd0);
        chk("rst_pend", {3'b0, req_pending}, 4'd0);
        chk("rst_ack", {3'b0, req_ack}, 4'd0);
        chk("rst_rem", remaining, 4'd0);
        chk("rst_fault", {3'b0, fault}, 4'd0);
        step(); step();
        @(negedge clk) rst = 1'b1;
        step();

        // Basic grant
        press_and_latch("basic");
        state = 2'b00;
        step();
        chk("g_walk", {3'b0, walk}, 4'd1);
        chk("g_dw", {3'b0, dont_walk}, 4'd0);
        chk("g_ack", {3'b0, req_ack}, 4'd1);
        chk("g_pend", {3'b0, req_pending}, 4'd0);
        chk("g_rem4", remaining, 4'd4);
        step();
        chk("w_ack_off", {3'b0, req_ack}, 4'd0);
        chk("w_rem3", remaining, 4'd3);
        step();
        chk("w_rem2", remaining, 4'd2);
        step();
        chk("w_rem1", remaining, 4'd1);
        chk("w_walk_last", {3'b0, walk}, 4'd1);
        step();
        chk("c_walk", {3'b0, walk}, 4'd0);
        chk("c_dw", {3'b0, dont_walk}, 4'd1);
        chk("c_rem3", remaining, 4'd3);
        chk("c_flash1", {3'b0, flash}, {3'b0, fl(1'b1)});
        step();
        chk("c_rem2", remaining, 4'd2);
        chk("c_flash2", {3'b0, flash}, {3'b0, fl(1'b0)});
        step();
        chk("c_rem1", remaining, 4'd1);
        chk("c_flash3", {3'b0, flash}, {3'b0, fl(1'b1)});
        step();
        chk("i_rem0", remaining, 4'd0);
        chk("i_flash", {3'b0, flash}, 4'd0);
        chk("i_walk", {3'b0, walk}, 4'd0);
        chk("i_dw", {3'b0, dont_walk}, 4'd1);

        // Bounce rejection
        for (int i = 0; i < 20; i++) begin
            ped_btn = ~ped_btn;
            step();
            chk("bounce_pend", {3'b0, req_pending}, 4'd0);
        end
        ped_btn = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Red entry without a request
        state = 2'b01;
        step();
        state = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("noreq_walk", {3'b0, walk}, 4'd0);
            chk("noreq_ack", {3'b0, req_ack}, 4'd0);
        end

        // Abort on the second WALK cycle
        state = 2'b01;
        press_and_latch("abort");
        state = 2'b00;
        step();
        chk("a_walk1", {3'b0, walk}, 4'd1);
        step();
        chk("a_rem3", remaining, 4'd3);
        state = 2'b01;
        step();
        chk("a_walk", {3'b0, walk}, 4'd0);
        chk("a_dw", {3'b0, dont_walk}, 4'd1);
        chk("a_rem", remaining, 4'd0);
        chk("a_pend", {3'b0, req_pending}, 4'd0);
        step();
        chk("a_idle_walk", {3'b0, walk}, 4'd0);

        // Fault is sticky and blocks grants
        state = 2'b10;
        step();
        chk("f_set", {3'b0, fault}, 4'd1);
        chk("f_dw", {3'b0, dont_walk}, 4'd1);
        state = 2'b01;
        step();
        chk("f_sticky", {3'b0, fault}, 4'd1);
        ped_btn = 1'b1;
        for (int i = 0; i < 6; i++) step();
        ped_btn = 1'b0;
        state = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("f_walk", {3'b0, walk}, 4'd0);
            chk("f_ack", {3'b0, req_ack}, 4'd0);
            chk("f_flash", {3'b0, flash}, 4'd0);
        end
        #2 rst = 1'b0;
        #1;
        chk("f_rst_clear", {3'b0, fault}, 4'd0);
        chk("f_rst_pend", {3'b0, req_pending}, 4'd0);
        @(negedge clk) rst = 1'b1;
        state = 2'b01;
        step();

        // Asynchronous reset in the middle of WALK
        press_and_latch("mid");
        state = 2'b00;
        step();
        chk("m_walk", {3'b0, walk}, 4'd1);
        #2 rst = 1'b0;
        #1;
        chk("m_rst_walk", {3'b0, walk}, 4'd0);
        chk("m_rst_dw", {3'b0, dont_walk}, 4'd1);
        chk("m_rst_rem", remaining, 4'd0);
        chk("m_rst_ack", {3'b0, req_ack}, 4'd0);
        @(negedge clk) rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ped_walk_ctrl.md
# ped_walk_ctrl

Pedestrian walk-signal controller that sits directly downstream of the traffic light controller and consumes its 2-bit light state. It synchronises and debounces a raw pedestrian push-button, latches the request, and grants a WALK interval only when the vehicle light enters red. The WALK interval is followed by a timed CLEAR interval. Any exit from red or an illegal light code forces the safe DONT_WALK indication immediately.

## Interface
- `WALK_CYCLES`, default 4: WALK interval length in clocks; legal range 1..15.
- `CLEAR_CYCLES`, default 3: CLEAR interval length in clocks; legal range 1..15.
- `DEBOUNCE`, default 3: consecutive stable samples required to accept a button level; legal range 1..15.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `state` input 2: vehicle light code; 00 red, 01 green, 11 yellow, 10 illegal.
- `ped_btn` input 1: raw asynchronous push-button, active-high.
- `walk` output 1: WALK lamp.
- `dont_walk` output 1: DONT_WALK lamp.
- `flash` output 1: DONT_WALK flash enable during CLEAR.
- `req_pending` output 1: a request is latched and not yet served.
- `req_ack` output 1: one-cycle pulse when a request is granted.
- `remaining` output 4: cycles left in the current WALK or CLEAR interval; 0 in IDLE.
- `fault` output 1: sticky flag; set by illegal `state` code 10.

## Operation
- **Button path:** 2-flop synchroniser → debounce counter → debounced level `btn_db`.
  - `btn_db` changes only after `DEBOUNCE` consecutive equal synchronised samples differing from the current `btn_db`.
  - A rising edge of `btn_db` sets `req_pending`.
- **Red-entry detect:** a `prev_state` register is reset to 01. `red_entry` = (`state`==00) && (`prev_state`!=00).
- **FSM states:** IDLE, WALK, CLEAR, FAULT.
  - **IDLE → WALK** on `red_entry` && `req_pending` && !`fault`.
    - Same edge: `req_ack`=1 for one cycle, `req_pending` cleared, `remaining`=`WALK_CYCLES`.
  - **WALK:** `walk`=1, `dont_walk`=0. `remaining` decrements each cycle.
    - When `remaining`==1 → CLEAR, `remaining`=`CLEAR_CYCLES`.
  - **CLEAR:** `walk`=0, `dont_walk`=1, `flash` per the Configuration section. `remaining` decrements each cycle.
    - When `remaining`==1 → IDLE, `remaining`=0.
  - **Abort:** in WALK or CLEAR, if `state`!=00 → IDLE next edge; `walk`=0, `dont_walk`=1, `remaining`=0. The request is not re-latched.
  - **Any state:** if `state`==10 → FAULT. `fault` is set and held until reset. In FAULT: `walk`=0, `dont_walk`=1, `flash`=0. No exit except reset.
- **Simultaneous events:**
  - A request edge on the same cycle as grant: the grant wins and the new request is dropped. `req_pending` ends 0.
  - A request arriving during WALK or CLEAR is latched for the next red entry.
  - A request arriving mid-red while IDLE waits for the next red entry; no late grant.
- `remaining` arithmetic is 4-bit unsigned with no wrap. It never decrements below 1 inside WALK or CLEAR.

## Timing
- **Reset values** (`rst`=0, asynchronous): FSM=IDLE, `walk`=0, `dont_walk`=1, `flash`=0, `req_pending`=0, `req_ack`=0, `remaining`=0, `fault`=0.
  - Synchroniser, debounce counter and `btn_db` are 0. `prev_state`=01.
- Reset asserted mid-WALK forces the reset values immediately, without waiting for a clock.
- **Button latency:** a clean press held high reaches `req_pending`=1 `DEBOUNCE`+3 edges after the first edge that samples `ped_btn` high.
- **Grant latency:** `walk`=1 and `req_ack`=1 on the first edge after the cycle in which `red_entry` is true.
- **Interval lengths:** `walk` is high for exactly `WALK_CYCLES` clocks and CLEAR lasts exactly `CLEAR_CYCLES` clocks, provided `state` stays 00 throughout.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`PED_FLASH_EN` defined:** in CLEAR, `flash` toggles every clock. It starts at 1 on the CLEAR entry edge and is forced to 0 on leaving CLEAR.
- **`PED_FLASH_EN` undefined:** `flash` is constant 0. CLEAR shows a steady `dont_walk`=1. All other behaviour is unchanged.

## Test plan
- **Basic grant:** reset, `state`=01; `ped_btn` high 10 cycles (`DEBOUNCE`=3) → `req_pending`=1 after 6 edges. Then `state`=00 → next edge `walk`=1, `req_ack` pulse, `remaining`=4,3,2,1. Then CLEAR `remaining`=3,2,1, then IDLE.
- **Bounce rejection:** `ped_btn` toggling every cycle for 20 cycles → `req_pending` stays 0.
- **Abort:** grant as in the basic-grant case; set `state`=01 on the 2nd WALK cycle → next edge `walk`=0, `dont_walk`=1, `remaining`=0, FSM IDLE, `req_pending`=0.
- **No request:** red entry with `req_pending`=0 → `walk` stays 0 and `req_ack` never pulses.
- **Fault:** `state`=10 for one cycle in IDLE → `fault`=1 sticky. A later request plus red entry produces no WALK. Asserting `rst` clears `fault`.
- **Flash:** with `PED_FLASH_EN` defined, CLEAR of 3 cycles → `flash`=1,0,1, then 0. With the macro undefined, `flash`=0 throughout.
